// File: rtl/seg7_reader_if.sv
// seg7_reader_if: display-side bus of the 7-segment read-back monitor.
//   digit_sel_n  : active-low digit enables (asynchronous to the reader clock)
//   segments_n   : active-low segments, bit0=a .. bit6=g (asynchronous)
//   value        : decoded nibbles, digit i at [4i+3:4i]
//   blank_mask   : 1 = digit i showed all segments off
//   invalid_mask : 1 = digit i showed a non-hex pattern
//   frame_valid  : one-cycle strobe, outputs updated this cycle
// master = display driver / consumer side, slave = seg7_reader.
interface seg7_reader_if #(
    parameter int unsigned DIGITS = 4
);
    logic [DIGITS-1:0]   digit_sel_n;
    logic [6:0]          segments_n;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   blank_mask;
    logic [DIGITS-1:0]   invalid_mask;
    logic                frame_valid;

    modport master (
        output digit_sel_n, segments_n,
        input  value, blank_mask, invalid_mask, frame_valid
    );

    modport slave (
        input  digit_sel_n, segments_n,
        output value, blank_mask, invalid_mask, frame_valid
    );
endinterface

// File: rtl/seg7_reader.sv
// seg7_reader: reads back a multiplexed active-low 7-segment display bus,
// decodes each digit to a hex nibble once it has been stable, and publishes
// a complete display word with a one-cycle strobe.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : seg7_reader_if.slave (display inputs, decoded outputs)
module seg7_reader #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    seg7_reader_if.slave bus
);

    localparam int unsigned SW = DIGITS + 7;
    localparam int unsigned CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_e;

    // Returns {invalid, blank, nibble}
    function automatic logic [5:0] decode_seg(input logic [6:0] seg_n);
        logic [5:0] r;
        case (seg_n)
            7'h40:   r = 6'h00;
            7'h79:   r = 6'h01;
            7'h24:   r = 6'h02;
            7'h30:   r = 6'h03;
            7'h19:   r = 6'h04;
            7'h12:   r = 6'h05;
            7'h02:   r = 6'h06;
            7'h78:   r = 6'h07;
            7'h00:   r = 6'h08;
            7'h18:   r = 6'h09;
            7'h08:   r = 6'h0A;
            7'h03:   r = 6'h0B;
            7'h46:   r = 6'h0C;
            7'h21:   r = 6'h0D;
            7'h06:   r = 6'h0E;
            7'h0E:   r = 6'h0F;
            7'h7F:   r = 6'b01_0000;
            default: r = 6'b10_0000;
        endcase
        return r;
    endfunction

    logic [SW-1:0]       sync1_q, sync1_d;
    logic [SW-1:0]       sync2_q, sync2_d;
    logic [SW-1:0]       prev_q, prev_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] slot_nib_q, slot_nib_d;
    logic [DIGITS-1:0]   slot_blank_q, slot_blank_d;
    logic [DIGITS-1:0]   slot_inv_q, slot_inv_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [DIGITS-1:0]   invalid_q, invalid_d;
    logic                frame_valid_q, frame_valid_d;

    logic                changed;
    logic                capture;
    logic [DIGITS-1:0]   sel_low;
    logic                one_low;
    logic [5:0]          dec;
    logic [DIGITS-1:0]   seen_set;
    logic                frame_done;

    always_comb begin
        sync1_d = {bus.digit_sel_n, bus.segments_n};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        changed = (sync2_q != prev_q);

        if (changed)               cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                       cnt_d = cnt_q + CW'(1);

        // A capture may coincide with a new change; prev_q still holds the
        // pattern that was stable for the whole count, so capture from it.
        capture = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE:    if (changed) state_d = SETTLE;
            SETTLE: begin
                if (cnt_q == CNT_MAX) begin
                    capture = 1'b1;
                    state_d = changed ? SETTLE : HELD;
                end
            end
            HELD:    if (changed) state_d = SETTLE;
            default: state_d = IDLE;
        endcase

        sel_low = ~prev_q[SW-1:7];
        one_low = $onehot(sel_low);
        dec     = decode_seg(prev_q[6:0]);

        slot_nib_d   = slot_nib_q;
        slot_blank_d = slot_blank_q;
        slot_inv_d   = slot_inv_q;
        seen_set     = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (capture && one_low && sel_low[i]) begin
                slot_nib_d[4*i +: 4] = dec[3:0];
                slot_blank_d[i]      = dec[4];
                slot_inv_d[i]        = dec[5];
                seen_set[i]          = 1'b1;
            end
        end

        frame_done    = &seen_q;
        seen_d        = (frame_done ? '0 : seen_q) | seen_set;
        value_d       = frame_done ? slot_nib_q   : value_q;
        blank_d       = frame_done ? slot_blank_q : blank_q;
        invalid_d     = frame_done ? slot_inv_q   : invalid_q;
        frame_valid_d = frame_done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            prev_q        <= '1;
            cnt_q         <= '0;
            state_q       <= IDLE;
            slot_nib_q    <= '0;
            slot_blank_q  <= '0;
            slot_inv_q    <= '0;
            seen_q        <= '0;
            value_q       <= '0;
            blank_q       <= '0;
            invalid_q     <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            slot_nib_q    <= slot_nib_d;
            slot_blank_q  <= slot_blank_d;
            slot_inv_q    <= slot_inv_d;
            seen_q        <= seen_d;
            value_q       <= value_d;
            blank_q       <= blank_d;
            invalid_q     <= invalid_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign bus.value        = value_q;
    assign bus.blank_mask   = blank_q;
    assign bus.invalid_mask = invalid_q;
    assign bus.frame_valid  = frame_valid_q;

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
Reads back a time-multiplexed, active-low 7-segment display bus: digit-select lines plus shared segment lines, as driven to the board display. Each digit's pattern is decoded back to a hex nibble. A digit is accepted only after it has been stable for a set time. When every digit has been captured, the block publishes a complete display word with a one-cycle strobe. It sits beside the display driver as a self-check and loopback monitor, or as the front end of a scraper for an external display.

Parameters:
DIGITS, 4, number of multiplexed digits; 1..8
STABLE_CYCLES, 8, consecutive equal samples required before a digit is accepted; >=2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
digit_sel_n  in  DIGITS  active-low digit enables; asynchronous to clk
segments_n  in  7  active-low segments; bit0=a, bit1=b, ..., bit6=g; asynchronous to clk
value  out  4*DIGITS  decoded nibbles; digit i at [4i+3:4i]
blank_mask  out  DIGITS  1 = digit i showed all segments off
invalid_mask  out  DIGITS  1 = digit i showed a non-hex pattern
frame_valid  out  1  one-cycle strobe; outputs updated this cycle

Behaviour:
- Synchroniser: two-flop synchroniser on all DIGITS+7 inputs. Reset value of the synchroniser flops is all ones (no digit, blank). Call the second-stage output S.
- Decode table, segments_n value (hex) -> nibble:
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9
  - 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F
  - 7F -> blank: nibble 0, blank bit set.
  - Any other pattern -> invalid: nibble 0, invalid bit set.
  - All-segments-on (00) decodes as 8, never as invalid.
- Stability counter: the counter width holds STABLE_CYCLES-1.
  - It clears to 0 on any cycle where S differs from the previous S.
  - Otherwise it increments, saturating at STABLE_CYCLES-1.
- FSM states:
  - IDLE: entered at reset. Go to SETTLE on any S change.
  - SETTLE: on an S change, stay in SETTLE with the counter cleared. When the counter reaches STABLE_CYCLES-1, perform a capture attempt and go to HELD.
  - HELD: no further captures. Go to SETTLE on any S change.
- Capture attempt: valid only if digit_sel_n in S has exactly one bit low.
  - If valid: write the nibble, blank flag and invalid flag into slot i, and set seen[i].
  - If zero or multiple bits are low: no write, but still go to HELD.
- Repeat capture: if slot i is captured again before the frame completes, the new data overwrites the old.
- Frame completion: on the clock after seen becomes all ones, on one edge:
  - value, blank_mask and invalid_mask load from the slots;
  - frame_valid is high for exactly that cycle;
  - seen clears to 0.
  Outputs hold their values between frames.
- Simultaneous events: if a capture of the final slot and a new S change occur together, the capture completes, then SETTLE restarts.
- Latency: a pin change to the point where a capture can occur takes 2 (synchroniser) + STABLE_CYCLES clocks. The last capture to frame_valid takes 1 clock.
- Reset values: value=0, blank_mask=0, invalid_mask=0, frame_valid=0, seen=0, counter=0, state=IDLE.
- Reset assertion mid-frame discards all partial slots immediately; no frame_valid is issued for that frame.

Test Plan:
1. Assert reset_n=0 with inputs toggling -> all outputs 0, frame_valid never high; release reset -> no strobe until a full frame is captured.
2. DIGITS=4, STABLE_CYCLES=8: drive digit 0..3 in order with patterns 40, 79, 24, 30, each dwelling 20 clocks -> exactly one frame_valid; value=16'h3210; blank_mask=0; invalid_mask=0.
3. Glitch: drive digit 1 = 19 for 5 clocks, then 12 for 20 clocks, with the other digits = 40 -> frame value[7:4]=5; the 4 is never captured; the strobe comes 1 clock after the last capture.
4. Drive digit 2 = 7F and digit 3 = 7E, the other digits = 00 -> value=16'h0088, blank_mask=4'b0100, invalid_mask=4'b1000.
5. Drive digit_sel_n=4'b1100 (two digits low) for 30 clocks, then digits 0..3 normally (pattern 0E) -> only the normal sequence captures; value=16'hFFFF; one strobe.
6. Capture digits 0 and 1, pulse reset_n low for 1 clock, then capture digits 2 and 3 only -> no frame_valid. Then capture digits 0 and 1 -> a frame_valid occurs, carrying only the post-reset data.
